// File: rtl/wb_stage.sv
// wb_stage: write-back stage of the integer pipeline.
// Registers the selected result for the register file one cycle after
// an instruction is accepted. When a load's data has not arrived yet, the
// stage parks in WAIT_LOAD with the load's fields latched. It completes the
// write when memory data becomes valid.
//
// Ports
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_valid/o_ready   handshake from MEM (accept = i_valid && o_ready)
//   i_ctrlWB          source select: 0 ALU, 1 load, 2 PC+4, 3 CSR
//   i_funct3          load type (LB/LH/LW/LD/LBU/LHU/LWU)
//   i_addrLow         low load-address bits, select the byte/half/word lane
//   i_regWrite, i_rd  write enable request and destination register
//   i_resultALU, i_pcPlus4, i_csrData   non-load sources
//   i_rdataValid, i_readData            memory response (aligned word)
//   o_wrEn, o_wrAddr, o_wrData          register-file write port
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_ctrlWB,
    input  logic [2:0]        i_funct3,
    input  logic [2:0]        i_addrLow,
    input  logic              i_regWrite,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [XLEN-1:0]   i_resultALU,
    input  logic [XLEN-1:0]   i_pcPlus4,
    input  logic [XLEN-1:0]   i_csrData,
    input  logic              i_rdataValid,
    input  logic [XLEN-1:0]   i_readData,
    output logic              o_wrEn,
    output logic [REG_AW-1:0] o_wrAddr,
    output logic [XLEN-1:0]   o_wrData
);

    typedef enum logic {IDLE, WAIT_LOAD} state_e;

    state_e            state_q,   state_d;
    logic [REG_AW-1:0] rd_q,      rd_d;
    logic              regwr_q,   regwr_d;
    logic [2:0]        f3_q,      f3_d;
    logic [2:0]        al_q,      al_d;
    logic              wr_en_q,   wr_en_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]   wr_data_q, wr_data_d;

    // Lane select and extension of a load. Misaligned addresses simply use
    // the truncated lane index, so a halfword at an odd address takes the
    // halfword lane that contains it.
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0]      f3,
                                                 input logic [2:0]      al,
                                                 input logic [XLEN-1:0] d);
        logic [5:0]      bsh, hsh, wsh;
        logic [XLEN-1:0] bs, hs, ws;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [31:0]     w;
        logic [XLEN-1:0] r;
        bsh = (XLEN == 64) ? {al, 3'b000}         : {1'b0, al[1:0], 3'b000};
        hsh = (XLEN == 64) ? {al[2:1], 4'b0000}   : {1'b0, al[1], 4'b0000};
        wsh = (XLEN == 64) ? {al[2], 5'b00000}    : 6'd0;
        bs  = d >> bsh;
        hs  = d >> hsh;
        ws  = d >> wsh;
        b   = bs[7:0];
        h   = hs[15:0];
        w   = ws[31:0];
        case (f3)
            3'b000:  r = XLEN'($signed(b));
            3'b001:  r = XLEN'($signed(h));
            3'b010:  r = XLEN'($signed(w));
            3'b100:  r = XLEN'(b);
            3'b101:  r = XLEN'(h);
            3'b110:  r = XLEN'(w);
            default: r = d;  // LD (and unused encodings) pass the whole word
        endcase
        return r;
    endfunction

    assign o_ready  = (state_q == IDLE);
    assign o_wrEn   = wr_en_q;
    assign o_wrAddr = wr_addr_q;
    assign o_wrData = wr_data_q;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        regwr_d   = regwr_q;
        f3_d      = f3_q;
        al_d      = al_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (i_ctrlWB != 2'd1) begin
                        wr_en_d   = i_regWrite && (i_rd != '0);
                        wr_addr_d = i_rd;
                        case (i_ctrlWB)
                            2'd0:    wr_data_d = i_resultALU;
                            2'd2:    wr_data_d = i_pcPlus4;
                            default: wr_data_d = i_csrData;
                        endcase
                    end else if (i_rdataValid) begin
                        wr_en_d   = i_regWrite && (i_rd != '0);
                        wr_addr_d = i_rd;
                        wr_data_d = load_ext(i_funct3, i_addrLow, i_readData);
                    end else begin
                        // Data not back yet: keep what is needed to finish later.
                        rd_d    = i_rd;
                        regwr_d = i_regWrite;
                        f3_d    = i_funct3;
                        al_d    = i_addrLow;
                        state_d = WAIT_LOAD;
                    end
                end
            end
            WAIT_LOAD: begin
                // i_valid is ignored here; MEM holds its instruction.
                if (i_rdataValid) begin
                    wr_en_d   = regwr_q && (rd_q != '0);
                    wr_addr_d = rd_q;
                    wr_data_d = load_ext(f3_q, al_q, i_readData);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            regwr_q   <= 1'b0;
            f3_q      <= '0;
            al_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            regwr_q   <= regwr_d;
            f3_q      <= f3_d;
            al_q      <= al_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a 32-bit and a 64-bit instance share one stimulus set.
// Expected writes are queued when an instruction is driven and popped when
// the write should appear.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, rdv, regw;
    logic [1:0]  ctrl;
    logic [2:0]  f3, al;
    logic [4:0]  rd;
    logic [63:0] alu, pc, csr, rdata;

    logic        rdy32, en32, rdy64, en64;
    logic [4:0]  addr32, addr64;
    logic [31:0] data32;
    logic [63:0] data64;

    typedef struct {
        logic        en;
        logic [4:0]  addr;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t sb64[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .REG_AW(5)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy32),
        .i_ctrlWB(ctrl), .i_funct3(f3), .i_addrLow(al), .i_regWrite(regw),
        .i_rd(rd), .i_resultALU(alu[31:0]), .i_pcPlus4(pc[31:0]),
        .i_csrData(csr[31:0]), .i_rdataValid(rdv), .i_readData(rdata[31:0]),
        .o_wrEn(en32), .o_wrAddr(addr32), .o_wrData(data32)
    );

    wb_stage #(.XLEN(64), .REG_AW(5)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(rdy64),
        .i_ctrlWB(ctrl), .i_funct3(f3), .i_addrLow(al), .i_regWrite(regw),
        .i_rd(rd), .i_resultALU(alu), .i_pcPlus4(pc),
        .i_csrData(csr), .i_rdataValid(rdv), .i_readData(rdata),
        .o_wrEn(en64), .o_wrAddr(addr64), .o_wrData(data64)
    );

    // Reference load extraction, written lane-by-lane.
    function automatic logic [63:0] ref_ext(input int xl, input logic [2:0] t,
                                            input logic [2:0] a, input logic [63:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        logic [63:0] r;
        if (xl == 32) begin
            b = d[8*a[1:0] +: 8];
            h = d[16*a[1] +: 16];
            w = d[31:0];
        end else begin
            b = d[8*a +: 8];
            h = d[16*a[2:1] +: 16];
            w = d[32*a[2] +: 32];
        end
        case (t)
            3'b000:  r = {{56{b[7]}}, b};
            3'b001:  r = {{48{h[15]}}, h};
            3'b010:  r = {{32{w[31]}}, w};
            3'b100:  r = {56'd0, b};
            3'b101:  r = {48'd0, h};
            3'b110:  r = {32'd0, w};
            default: r = d;
        endcase
        if (xl == 32) r = {32'd0, r[31:0]};
        return r;
    endfunction

    task automatic drive(input logic v, input logic [1:0] c, input logic [2:0] t,
                         input logic [2:0] a, input logic w, input logic [4:0] r,
                         input logic [63:0] s, input logic rv, input logic [63:0] d);
        valid = v; ctrl = c; f3 = t; al = a; regw = w; rd = r;
        alu = s; pc = s ^ 64'h1111; csr = s ^ 64'h2222;
        rdv = rv; rdata = d;
    endtask

    task automatic idle();
        valid = 1'b0; rdv = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 64'd0, 0, 64'd0);
        tick(); tick();
        total++; if (en32 !== 1'b0)  begin bad++; $display("FAIL reset_en got=%0b exp=0", en32); end
        total++; if (addr32 !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", addr32); end
        total++; if (data32 !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", data32); end
        rst_n = 1'b1;
        tick();
        total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", rdy32); end
        e.en = 1'b0;
        total++; if (en32 !== e.en) begin bad++; $display("FAIL reset_idle_en got=%0b exp=0", en32); end
    endtask

    // Non-load sources; first entry is the ALU example, last has regWrite=0.
    task automatic test_alu();
        logic [1:0]  cs [4] = '{2'd0, 2'd2, 2'd3, 2'd0};
        logic [4:0]  rs [4] = '{5'd5, 5'd7, 5'd31, 5'd9};
        logic        ws [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] vs [4] = '{64'h1234, 64'h200, 64'hDEAD_BEEF, 64'h55};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1, cs[i], 0, 0, ws[i], rs[i], vs[i], 0, 64'd0);
            e.en = ws[i]; e.addr = rs[i];
            e.data = (cs[i] == 2'd0) ? vs[i] : (cs[i] == 2'd2) ? (vs[i] ^ 64'h1111) : (vs[i] ^ 64'h2222);
            sb.push_back(e);
            tick();
            idle();
            e = sb.pop_front();
            total++; if (en32 !== e.en) begin bad++; $display("FAIL alu%0d_en got=%0b exp=%0b", i, en32, e.en); end
            total++; if (addr32 !== e.addr) begin bad++; $display("FAIL alu%0d_addr got=%0d exp=%0d", i, addr32, e.addr); end
            total++; if (data32 !== e.data[31:0]) begin bad++; $display("FAIL alu%0d_data got=%h exp=%h", i, data32, e.data[31:0]); end
            tick();
            total++; if (en32 !== 1'b0) begin bad++; $display("FAIL alu%0d_pulse got=%0b exp=0", i, en32); end
        end
    endtask

    // Loads with data in the same cycle, issued back to back on both widths.
    task automatic test_load_same();
        logic [2:0]  ts [6] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        logic [2:0]  t, a;
        logic [4:0]  r;
        logic [63:0] d;
        exp_t e;
        drive(1, 1, 3'b000, 3'd3, 1, 5'd8, 64'd0, 1, 64'h80FF_FFFF);
        e.en = 1; e.addr = 5'd8; e.data = 64'hFFFF_FF80; sb.push_back(e);
        tick();
        drive(1, 1, 3'b100, 3'd3, 1, 5'd8, 64'd0, 1, 64'h80FF_FFFF);
        e.data = 64'h0000_0080; sb.push_back(e);
        for (int i = 0; i < 26; i++) begin
            e = sb.pop_front();
            total++; if (en32 !== e.en) begin bad++; $display("FAIL ld%0d_en got=%0b exp=%0b", i, en32, e.en); end
            total++; if (addr32 !== e.addr) begin bad++; $display("FAIL ld%0d_addr got=%0d exp=%0d", i, addr32, e.addr); end
            total++; if (data32 !== e.data[31:0]) begin bad++; $display("FAIL ld%0d_data got=%h exp=%h", i, data32, e.data[31:0]); end
            if (sb64.size() != 0) begin
                e = sb64.pop_front();
                total++; if (data64 !== e.data) begin bad++; $display("FAIL ld64_%0d_data got=%h exp=%h", i, data64, e.data); end
            end
            if (i == 0) begin
                tick();
            end else if (i < 25) begin
                t = ts[$urandom_range(0, 5)];
                a = 3'($urandom_range(0, 7));
                r = 5'($urandom_range(1, 31));
                d = {$urandom, $urandom};
                drive(1, 1, t, a, 1, r, 64'd0, 1, d);
                e.en = 1; e.addr = r; e.data = ref_ext(32, t, a, d); sb.push_back(e);
                e.data = ref_ext(64, t, a, d); sb64.push_back(e);
                tick();
            end
        end
        idle();
        tick();
    endtask

    // Load waits 3 cycles for data; MEM-side fields change meanwhile and
    // must not affect the latched load.
    task automatic test_load_wait();
        exp_t e;
        drive(1, 1, 3'b001, 3'd2, 1, 5'd12, 64'd0, 0, 64'h7FFE_0000);
        e.en = 1; e.addr = 5'd12; e.data = 64'h7FFE; sb.push_back(e);
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (rdy32 !== 1'b0) begin bad++; $display("FAIL wait%0d_ready got=%0b exp=0", i, rdy32); end
            total++; if (en32 !== 1'b0) begin bad++; $display("FAIL wait%0d_en got=%0b exp=0", i, en32); end
            drive(1, 1, 3'b000, 3'd0, 1, 5'd3, 64'd0, (i == 2), 64'h7FFE_0000);
            tick();
        end
        idle();
        e = sb.pop_front();
        total++; if (en32 !== e.en) begin bad++; $display("FAIL wait_en got=%0b exp=%0b", en32, e.en); end
        total++; if (addr32 !== e.addr) begin bad++; $display("FAIL wait_addr got=%0d exp=%0d", addr32, e.addr); end
        total++; if (data32 !== e.data[31:0]) begin bad++; $display("FAIL wait_data got=%h exp=%h", data32, e.data[31:0]); end
        total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL wait_ready_after got=%0b exp=1", rdy32); end
        tick();
        total++; if (en32 !== 1'b0) begin bad++; $display("FAIL wait_pulse got=%0b exp=0", en32); end
    endtask

    task automatic test_rd0();
        exp_t e;
        drive(1, 2, 0, 0, 1, 5'd0, 64'h100 ^ 64'h1111, 0, 64'd0);
        e.en = 0; e.addr = 0; e.data = 64'h100; sb.push_back(e);
        tick();
        idle();
        e = sb.pop_front();
        total++; if (en32 !== e.en) begin bad++; $display("FAIL rd0_en got=%0b exp=%0b", en32, e.en); end
        total++; if (data32 !== e.data[31:0]) begin bad++; $display("FAIL rd0_data got=%h exp=%h", data32, e.data[31:0]); end
    endtask

    task automatic test_reset_wait();
        drive(1, 1, 3'b010, 3'd0, 1, 5'd4, 64'd0, 0, 64'h1234_5678);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rdv = 1'b1;
        tick();
        rdv = 1'b0;
        total++; if (en32 !== 1'b0) begin bad++; $display("FAIL rstwait_en got=%0b exp=0", en32); end
        total++; if (rdy32 !== 1'b1) begin bad++; $display("FAIL rstwait_ready got=%0b exp=1", rdy32); end
        total++; if (data32 !== 32'd0) begin bad++; $display("FAIL rstwait_data got=%h exp=0", data32); end
        tick();
        total++; if (en32 !== 1'b0) begin bad++; $display("FAIL rstwait_late_en got=%0b exp=0", en32); end
    endtask

    task automatic test_spurious();
        exp_t e;
        drive(1, 0, 0, 0, 1, 5'd6, 64'hABCD, 0, 64'd0);
        e.en = 1; e.addr = 5'd6; e.data = 64'hABCD; sb.push_back(e);
        tick();
        drive(0, 1, 3'b010, 0, 1, 5'd9, 64'd0, 1, 64'hFFFF);
        tick();
        idle();
        e = sb.pop_front();
        total++; if (en32 !== 1'b0) begin bad++; $display("FAIL spur_en got=%0b exp=0", en32); end
        total++; if (data32 !== e.data[31:0]) begin bad++; $display("FAIL spur_data got=%h exp=%h", data32, e.data[31:0]); end
        total++; if (addr32 !== e.addr) begin bad++; $display("FAIL spur_addr got=%0d exp=%0d", addr32, e.addr); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  c;
        logic [4:0]  r;
        logic [63:0] v;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            c = (i % 3 == 0) ? 2'd0 : (i % 3 == 1) ? 2'd2 : 2'd3;
            r = 5'($urandom_range(0, 31));
            v = {$urandom, $urandom};
            drive(1, c, 0, 0, 1, r, v, 0, 64'd0);
            e.en = (r != 0); e.addr = r;
            e.data = (c == 2'd0) ? v : (c == 2'd2) ? (v ^ 64'h1111) : (v ^ 64'h2222);
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            total++; if (en32 !== e.en) begin bad++; $display("FAIL b2b%0d_en got=%0b exp=%0b", i, en32, e.en); end
            total++; if (data32 !== e.data[31:0]) begin bad++; $display("FAIL b2b%0d_data got=%h exp=%h", i, data32, e.data[31:0]); end
        end
        idle();
        tick();
    endtask

    task automatic test_xlen64();
        logic [2:0]  ts [4] = '{3'b110, 3'b011, 3'b010, 3'b000};
        logic [2:0]  as [4] = '{3'd4, 3'd0, 3'd4, 3'd7};
        logic [63:0] ds [4] = '{64'hFFFF_FFFF_0000_0000, 64'h8123_4567_89AB_CDEF,
                                64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] xs [4] = '{64'h0000_0000_FFFF_FFFF, 64'h8123_4567_89AB_CDEF,
                                64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, ts[i], as[i], 1, 5'd10, 64'd0, 1, ds[i]);
            e.en = 1; e.addr = 5'd10; e.data = xs[i]; sb64.push_back(e);
            tick();
            idle();
            e = sb64.pop_front();
            total++; if (en64 !== e.en) begin bad++; $display("FAIL x64_%0d_en got=%0b exp=%0b", i, en64, e.en); end
            total++; if (data64 !== e.data) begin bad++; $display("FAIL x64_%0d_data got=%h exp=%h", i, data64, e.data); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_same();
        test_load_wait();
        test_rd0();
        test_reset_wait();
        test_spurious();
        test_back_to_back();
        test_xlen64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, data width of all data ports; legal values 32 and 64.
REQ-002 Parameter REG_AW, default 5, register-file address width.
REQ-003 Port i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port i_rst_n  input  1  synchronous, active-low reset.
REQ-005 Port i_valid  input  1  instruction presented by the MEM stage.
REQ-006 Port o_ready  output  1  stage can accept an instruction this cycle.
REQ-007 Port i_ctrlWB  input  2  source select: 0 = ALU, 1 = load, 2 = PC+4, 3 = CSR.
REQ-008 Port i_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 110 LWU; 011 LD only when XLEN=64.
REQ-009 Port i_addrLow  input  3  low bits of the load address; only bits [1:0] are used when XLEN=32.
REQ-010 Port i_regWrite  input  1  instruction writes the register file.
REQ-011 Port i_rd  input  REG_AW  destination register.
REQ-012 Port i_resultALU, i_pcPlus4, i_csrData  input  XLEN  source operands.
REQ-013 Port i_rdataValid  input  1  load data from memory is valid this cycle.
REQ-014 Port i_readData  input  XLEN  raw aligned memory word.
REQ-015 Port o_wrEn  output  1  register-file write strobe.
REQ-016 Port o_wrAddr  output  REG_AW  register-file write address.
REQ-017 Port o_wrData  output  XLEN  register-file write data.

Function
REQ-018 The FSM SHALL have two states: IDLE and WAIT_LOAD.
REQ-019 o_ready SHALL be 1 in IDLE and 0 in WAIT_LOAD (combinational from state).
REQ-020 An instruction is accepted in a cycle where i_valid && o_ready.
REQ-021 For an accepted non-load (i_ctrlWB != 1), the stage SHALL register the selected source into o_wrData, i_rd into o_wrAddr, and (i_regWrite && i_rd != 0) into o_wrEn, all visible at the next edge (latency 1).
REQ-022 For an accepted load with i_rdataValid=1 in the same cycle, the stage SHALL write the extracted data with latency 1 and remain in IDLE.
REQ-023 For an accepted load with i_rdataValid=0, the stage SHALL latch rd, regWrite, funct3 and addrLow, move to WAIT_LOAD, and hold o_wrEn at 0.
REQ-024 In WAIT_LOAD, the first cycle with i_rdataValid=1 SHALL produce the write at the next edge using the latched fields and return the FSM to IDLE.
REQ-025 In WAIT_LOAD, i_valid SHALL be ignored; MEM holds its instruction stable.
REQ-026 o_wrEn SHALL be a single-cycle pulse per completed instruction and 0 in every cycle with no completion.
REQ-027 Load extraction: byte lane = addrLow (addrLow[1:0] when XLEN=32); half lane = addrLow[2:1] (addrLow[1] when XLEN=32); word lane = addrLow[2] when XLEN=64.
REQ-028 Load extension: LB, LH and LW sign-extend to XLEN; LBU, LHU and LWU zero-extend; LW is a full word when XLEN=32.
REQ-029 Misaligned loads SHALL use the lane given by the truncated address bits; no trap is raised.
REQ-030 Writes with rd=0 SHALL leave o_wrEn at 0; o_wrAddr and o_wrData still update.
REQ-031 An i_rdataValid pulse while in IDLE with no load accepted SHALL be ignored.

Reset
REQ-032 While i_rst_n=0 at a clock edge: FSM goes to IDLE, o_wrEn=0, o_wrAddr=0, o_wrData=0, and all latched fields are cleared.
REQ-033 Reset asserted during WAIT_LOAD SHALL abandon the pending load; no write is issued after reset deasserts.
REQ-034 o_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-035 ALU op, ctrlWB=0, rd=5, resultALU=0x0000_1234 -> next cycle wrEn=1, wrAddr=5, wrData=0x0000_1234.
REQ-036 LB, addrLow=3, readData=0x80FF_FFFF, rdataValid in the same cycle -> wrData=0xFFFF_FF80; LBU with the same inputs -> wrData=0x0000_0080.
REQ-037 LH, addrLow=2, rdataValid delayed 3 cycles, readData=0x7FFE_0000 -> ready=0 for 3 cycles, then one write of 0x0000_7FFE, then ready=1.
REQ-038 JAL, ctrlWB=2, rd=0, pcPlus4=0x100 -> wrEn stays 0 and wrData=0x100.
REQ-039 Load pending in WAIT_LOAD, rst_n=0 for 1 cycle, then rdataValid=1 -> no wrEn pulse and FSM in IDLE.
REQ-040 XLEN=64, LWU, addrLow=4, readData=0xFFFF_FFFF_0000_0000 -> wrData=0x0000_0000_FFFF_FFFF.
